// File: rtl/pmod_pkg.sv
// Shared constants and types for the PMOD button conditioner.
package pmod_pkg;

    // Active-low button levels as seen on the pins and on btn_level.
    localparam logic BTN_RELEASED = 1'b1;
    localparam logic BTN_PRESSED  = 1'b0;

    // 20 ms at 12 MHz.
    localparam int DEBOUNCE_20MS_12MHZ = 240000;

    // The encoding matches the active-low level that each state presents.
    typedef enum logic {
        ST_PRESSED  = 1'b0,
        ST_RELEASED = 1'b1
    } btn_state_t;

endpackage

// File: rtl/pmod_debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter,
// RELEASED/PRESSED state machine and optional press/release strobes.
// Strobe registers exist only when PMOD_DEBOUNCE_PULSE_EN is defined.
// Otherwise the strobe outputs are tied low.
module debounce_channel
    import pmod_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_20MS_12MHZ,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    // A new value is accepted on the edge that would otherwise push the count past its last value.
    assign differ = (s2 != btn_level);
    assign accept = differ && (cnt == CNT_LAST);

    // Bring the asynchronous pin into the clk domain. The reset value reads as released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= BTN_RELEASED;
            s2 <= BTN_RELEASED;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Filter FSM. Any sample that agrees with the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RELEASED;
            btn_level <= BTN_RELEASED;
            cnt       <= '0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
            case (state)
                ST_RELEASED: begin
                    state     <= ST_PRESSED;
                    btn_level <= BTN_PRESSED;
                end
                default: begin
                    state     <= ST_RELEASED;
                    btn_level <= BTN_RELEASED;
                end
            endcase
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PMOD_DEBOUNCE_PULSE_EN
    // The strobes are registered alongside btn_level, so each one is coincident with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= accept && (state == ST_RELEASED);
            release_pulse <= accept && (state == ST_PRESSED);
        end
    end
`else
    assign press_pulse   = 1'b0;
    assign release_pulse = 1'b0;
`endif

endmodule

// File: rtl/pmod_debounce.sv
// Multi-channel PMOD button conditioner. It contains one independent
// debounce_channel per pin. The optional strobe logic is controlled by
// PMOD_DEBOUNCE_PULSE_EN; btn_level behaviour is the same in both builds.
module pmod_debounce
    import pmod_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int STABLE_CYCLES = DEBOUNCE_20MS_12MHZ,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pmod_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw           (pmod_raw[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule
